// File: rtl/iir_deemph.sv
// First-order fixed-point IIR de-emphasis: y[n] = DQ(B0*x[n] + B1*x[n-1]) + DQ(A1*y[n-1]).
// Latency 3 cycles pop-to-push (one sample per 4 cycles); a full downstream FIFO holds the sample in S_OUT with no further pops.
module iir_deemph #(
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = 10,
  parameter int B0         = 178,
  parameter int B1         = 178,
  parameter int A1         = 666
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int W2 = 2 * DATA_WIDTH;

  localparam logic signed [W2-1:0] B0_W = W2'(B0);
  localparam logic signed [W2-1:0] B1_W = W2'(B1);
  localparam logic signed [W2-1:0] A1_W = W2'(A1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_SUM  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                         state_q;
  logic signed [DATA_WIDTH-1:0]   x_q;
  logic signed [DATA_WIDTH-1:0]   x1_q;
  logic signed [DATA_WIDTH-1:0]   y1_q;
  logic signed [DATA_WIDTH-1:0]   y_q;
  logic signed [W2-1:0]           px_q;
  logic signed [W2-1:0]           py_q;

  logic signed [W2-1:0]           px_d;
  logic signed [W2-1:0]           py_d;
  logic signed [DATA_WIDTH-1:0]   y_d;

  // Operands are sign-extended to full product width before multiplying.
  assign px_d = B0_W * W2'(x_q) + B1_W * W2'(x1_q);
  assign py_d = A1_W * W2'(y1_q);
  // Each term is floored separately; the sum wraps to the sample width.
  assign y_d  = DATA_WIDTH'((px_q >>> QUANT_BITS) + (py_q >>> QUANT_BITS));

  // Reset gates the pop strobe so an idle FSM held in reset never drains upstream.
  assign in_rd_en  = !reset && (state_q == S_IDLE) && !in_empty;
  assign out_wr_en = (state_q == S_OUT) && !out_full;
  assign out_din   = (state_q == S_OUT) ? y_q : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      y_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!in_empty) begin
            x_q     <= in_dout;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          px_q    <= px_d;
          py_q    <= py_d;
          state_q <= S_SUM;
        end
        S_SUM: begin
          y_q     <= y_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          // History advances only when the sample actually leaves.
          if (!out_full) begin
            x1_q    <= x_q;
            y1_q    <= y_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_deemph.sv
// Bench for iir_deemph: FIFO models on both sides, fixed vectors, corner sequences and a random stream vs a floor-division model.
module tb_iir_deemph;

  logic        clock;
  logic        reset;
  logic [31:0] in_dout;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] out_din;
  logic        out_full;
  logic        out_wr_en;

  iir_deemph dut (
    .clock    (clock),
    .reset    (reset),
    .in_dout  (in_dout),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .out_din  (out_din),
    .out_full (out_full),
    .out_wr_en(out_wr_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  int  in_q[$];
  int  exp_q[$];
  int  pops = 0;
  int  pushes = 0;
  int  cyc = 0;
  int  pop_cyc = 0;
  int  in_stall_pct = 0;
  int  out_stall_pct = 0;
  bit  force_full = 1'b0;
  bit  last_rd = 1'b0;
  bit  last_wr = 1'b0;
  logic [31:0] last_din = '0;

  longint mx1 = 0;
  longint my1 = 0;

  function automatic longint floor_div1024(longint v);
    longint q;
    q = v / 1024;
    if (v < 0 && (v % 1024) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int model_step(int x);
    longint ff;
    longint fb;
    int     y;
    ff  = 178 * longint'(x) + 178 * mx1;
    fb  = 666 * my1;
    y   = int'(floor_div1024(ff) + floor_div1024(fb));
    mx1 = x;
    my1 = y;
    return y;
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // FIFO models: commit last cycle's handshakes, drive new inputs, sample outputs mid-cycle.
  initial begin
    in_empty = 1'b1;
    in_dout  = '0;
    out_full = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (last_rd) begin
        pops++;
        pop_cyc = cyc;
        if (in_q.size() > 0) void'(in_q.pop_front());
      end
      if (last_wr) begin
        pushes++;
        check("pop_to_push_ge3", (cyc - pop_cyc >= 3) ? 1 : 0, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_push", 1, 0);
        end else begin
          check("out_din", $signed(last_din), exp_q.pop_front());
        end
      end
      in_empty = (in_q.size() == 0) || ($urandom_range(0, 99) < in_stall_pct);
      in_dout  = (in_q.size() > 0) ? in_q[0] : $urandom;
      out_full = force_full || ($urandom_range(0, 99) < out_stall_pct);
      #1;
      if (in_rd_en) begin
        check("rd_when_busy", pops - pushes, 0);
        check("rd_when_empty", int'(in_empty), 0);
      end
      if (out_wr_en) check("wr_when_full", int'(out_full), 0);
      last_rd  = in_rd_en;
      last_wr  = out_wr_en;
      last_din = out_din;
    end
  end

  task automatic tick();
    @(negedge clock);
    #3;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    #1;
    check("rst_rd_en", int'(in_rd_en), 0);
    check("rst_wr_en", int'(out_wr_en), 0);
    check("rst_out_din", int'(out_din), 0);
    tick();
    tick();
    in_q.delete();
    exp_q.delete();
    pops   = 0;
    pushes = 0;
    mx1    = 0;
    my1    = 0;
    reset  = 1'b0;
  endtask

  task automatic wait_drain(string name, int budget);
    int k;
    k = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
      tick();
      k++;
    end
    if (in_q.size() > 0 || exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d inputs and %0d outputs outstanding, expected 0", name, in_q.size(), exp_q.size());
      in_q.delete();
      exp_q.delete();
    end
  endtask

  typedef struct packed {
    int                       n;
    logic signed [2:0][31:0]  xin;
    logic signed [2:0][31:0]  yexp;
  } vec_t;

  vec_t tbl[5];

  task automatic set_vec(int idx, int n, int x0, int x1, int x2, int y0, int y1, int y2);
    tbl[idx].n       = n;
    tbl[idx].xin[0]  = x0;
    tbl[idx].xin[1]  = x1;
    tbl[idx].xin[2]  = x2;
    tbl[idx].yexp[0] = y0;
    tbl[idx].yexp[1] = y1;
    tbl[idx].yexp[2] = y2;
  endtask

  initial begin
    int p0;
    int w0;
    int k;
    int x;
    reset = 1'b1;
    #2;
    check("init_rd_en", int'(in_rd_en), 0);
    check("init_out_din", int'(out_din), 0);

    set_vec(0, 3,  1024,    0, 0,  178,  293, 190);
    set_vec(1, 2, -1024,    0, 0, -178, -294,   0);
    set_vec(2, 2,  1024, 1024, 0,  178,  471,   0);
    set_vec(3, 2,    -1,    0, 0,   -1,   -2,   0);
    set_vec(4, 2,  2048,    0, 0,  356,  587,   0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      for (int j = 0; j < tbl[i].n; j++) begin
        in_q.push_back(tbl[i].xin[j]);
        exp_q.push_back(tbl[i].yexp[j]);
      end
      wait_drain("vector", 100);
    end

    // Downstream full from the start: the sample parks in S_OUT.
    do_reset();
    force_full = 1'b1;
    in_q.push_back(1024);  exp_q.push_back(178);
    in_q.push_back(0);     exp_q.push_back(293);
    in_q.push_back(0);     exp_q.push_back(190);
    repeat (14) tick();
    check("bp_pushes", pushes, 0);
    check("bp_pops", pops, 1);
    force_full = 1'b0;
    wait_drain("backpressure", 100);
    check("bp_pop_push_balance", pops - pushes, 0);

    // Starved upstream between samples.
    do_reset();
    in_q.push_back(1024);  exp_q.push_back(178);
    wait_drain("starve_a", 50);
    p0 = pops;
    w0 = pushes;
    repeat (20) tick();
    check("starve_pops", pops - p0, 0);
    check("starve_pushes", pushes - w0, 0);
    in_q.push_back(0);     exp_q.push_back(293);
    wait_drain("starve_b", 50);

    // Reset while the first sample is in S_SUM.
    do_reset();
    in_q.push_back(1024);  exp_q.push_back(178);
    k = 0;
    while (pops == 0 && k < 50) begin
      tick();
      k++;
    end
    check("midrst_popped", pops, 1);
    do_reset();
    in_q.push_back(1024);  exp_q.push_back(178);
    wait_drain("midrst", 50);

    // Random stream with random stalls on both sides.
    do_reset();
    in_stall_pct  = 30;
    out_stall_pct = 30;
    for (int i = 0; i < 1000; i++) begin
      x = int'($urandom_range(0, 65535)) - 32768;
      in_q.push_back(x);
      exp_q.push_back(model_step(x));
    end
    wait_drain("stream", 40000);
    repeat (8) tick();
    check("stream_pops", pops, 1000);
    check("stream_pushes", pushes, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
